// File: rtl/keypad_move_scanner.sv
// Keypad scanner for the tic-tac-toe game: scans a 4x3 matrix, debounces a press,
// maps it to cell 1..9 and issues a legal-move, reject or restart strobe.
module keypad_move_scanner #(
  parameter int SCAN_DIV       = 24999,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  input  logic [17:0] board,
  input  logic [1:0]  result,
  output logic [3:0]  key_data,
  output logic        key_valid,
  output logic        key_reject,
  output logic        restart,
  output logic [1:0]  dbg_state
);

  localparam int TW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_sync;
  logic [3:0]    r_row_lat;
  logic [TW-1:0] r_tick_cnt;
  logic [DW-1:0] r_cnt;
  logic [2:0]    r_key_col;
  logic [3:0]    r_key_data;
  logic          r_key_valid;
  logic          r_key_reject;
  logic          r_restart;

  logic          w_tick;
  logic          w_row_valid;
  logic          w_deb_done;
  logic [1:0]    w_r;
  logic [1:0]    w_c;
  logic [3:0]    w_cell;
  logic          w_cell_free;
  logic          w_is_cell;
  logic          w_is_star;

  assign w_tick      = (r_tick_cnt == TW'(SCAN_DIV));
  assign w_row_valid = $onehot(r_row_sync);
  assign w_deb_done  = (r_cnt == DW'(DEBOUNCE_TICKS - 1));

  // Key position comes from the latched row and the frozen column drive.
  always_comb begin
    w_r = 2'd3;
    case (r_row_lat)
      4'b0001: w_r = 2'd0;
      4'b0010: w_r = 2'd1;
      4'b0100: w_r = 2'd2;
      default: w_r = 2'd3;
    endcase
    w_c = 2'd2;
    case (r_key_col)
      3'b001:  w_c = 2'd0;
      3'b010:  w_c = 2'd1;
      default: w_c = 2'd2;
    endcase
    w_cell      = ({2'b00, w_r} * 4'd3) + {2'b00, w_c} + 4'd1;
    w_is_cell   = (w_r != 2'd3);
    w_is_star   = (w_r == 2'd3) && (w_c == 2'd0);
    w_cell_free = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (w_cell == 4'(k)) w_cell_free = ~(board[19-2*k] | board[18-2*k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_SCAN;
      r_row_meta   <= '0;
      r_row_sync   <= '0;
      r_row_lat    <= '0;
      r_tick_cnt   <= '0;
      r_cnt        <= '0;
      r_key_col    <= 3'b001;
      r_key_data   <= '0;
      r_key_valid  <= 1'b0;
      r_key_reject <= 1'b0;
      r_restart    <= 1'b0;
    end else begin
      r_row_meta   <= key_row;
      r_row_sync   <= r_row_meta;
      r_key_valid  <= 1'b0;
      r_key_reject <= 1'b0;
      r_restart    <= 1'b0;
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_row_valid) begin
              r_row_lat <= r_row_sync;
              r_cnt     <= '0;
              r_state   <= S_DEBOUNCE;
            end else begin
              r_key_col <= {r_key_col[1:0], r_key_col[2]};
            end
          end
          S_DEBOUNCE: begin
            if (r_row_sync != r_row_lat) begin
              r_state <= S_SCAN;
            end else if (w_deb_done) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
              if (w_is_cell) begin
                if (result == 2'b00 && w_cell_free) begin
                  r_key_valid <= 1'b1;
                  r_key_data  <= w_cell;
                end else begin
                  r_key_reject <= 1'b1;
                end
              end else if (w_is_star) begin
                r_restart <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            // Only an unbroken run of empty readings counts as a release.
            if (r_row_sync != 4'b0000) begin
              r_cnt <= '0;
            end else if (w_deb_done) begin
              r_cnt   <= '0;
              r_state <= S_SCAN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign key_col    = r_key_col;
  assign key_data   = r_key_data;
  assign key_valid  = r_key_valid;
  assign key_reject = r_key_reject;
  assign restart    = r_restart;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_keypad_move_scanner.sv
// Bench for keypad_move_scanner: a physical keypad model drives the rows, a rule-level
// model queues the expected strobe per press and a monitor checks what comes out.
module tb_keypad_move_scanner;

  localparam int SD = 3;
  localparam int DT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [17:0] board;
  logic [1:0]  result;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_reject;
  logic        restart;
  logic [1:0]  dbg_state;

  logic [3:0]  kp_rows;
  logic [1:0]  kp_col;
  logic        kp_on;

  int          total = 0;
  int          bad = 0;
  logic [5:0]  exp_q[$];
  logic [3:0]  m_last;

  keypad_move_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .board(board), .result(result), .key_data(key_data),
    .key_valid(key_valid), .key_reject(key_reject), .restart(restart),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Pressed keys connect their row to the column line only while it is driven.
  assign key_row = (kp_on && key_col[kp_col]) ? kp_rows : 4'b0000;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome of pressing row r, column c with the current board and result.
  task automatic expect_key(input int r, input int c);
    int k;
    if (r < 3) begin
      k = 3 * r + c + 1;
      if (result == 2'b00 && board[19-2*k] == 1'b0 && board[18-2*k] == 1'b0) begin
        m_last = 4'(k);
        exp_q.push_back({2'd1, m_last});
      end else begin
        exp_q.push_back({2'd2, m_last});
      end
    end else if (c == 0) begin
      exp_q.push_back({2'd3, m_last});
    end
  endtask

  task automatic hold_release(input int hold);
    kp_on = 1'b1;
    cycles(hold);
    kp_on = 1'b0;
    cycles(40);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic press(input int r, input int c);
    kp_rows = 4'(1 << r);
    kp_col  = 2'(c);
    expect_key(r, c);
    hold_release(60);
  endtask

  // Monitor: every strobe must match the oldest expected entry.
  initial begin : monitor
    int   n;
    int   kind;
    logic prev;
    logic [5:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      n = int'(key_valid === 1'b1) + int'(key_reject === 1'b1) + int'(restart === 1'b1);
      if (n > 0) begin
        check("single_strobe", n, 1);
        check("strobe_gap", int'(prev), 0);
        kind = key_valid ? 1 : (key_reject ? 2 : 3);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got kind %0d data %0d expected none at %0t",
                   kind, key_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", kind, int'(e[5:4]));
          check("key_data", int'(key_data), int'(e[3:0]));
        end
      end
      prev = (n > 0);
    end
  end

  initial begin : driver
    bit seen;
    int v;
    rst = 1'b1; kp_on = 1'b0; kp_rows = '0; kp_col = '0;
    board = '0; result = '0; m_last = '0;
    cycles(3);
    check("rst_key_col", int'(key_col), 1);
    check("rst_key_data", int'(key_data), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_reject", int'(key_reject), 0);
    check("rst_restart", int'(restart), 0);
    check("rst_state", int'(dbg_state), 0);

    // Idle scan: the column advances once per 4-cycle tick.
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      check("idle_key_col", int'(key_col), 1 << (((n + 1) / 4) % 3));
    end
    check("idle_key_data", int'(key_data), 0);

    press(0, 1);
    board[15:14] = 2'b01;
    press(0, 1);
    board = '0;
    result = 2'b01;
    press(2, 2);
    press(3, 0);
    result = 2'b00;

    // Key 5 bounces before settling.
    kp_rows = 4'b0010;
    kp_col  = 2'd1;
    for (int i = 0; i < 3; i++) begin
      kp_on = 1'b1; cycles(4);
      kp_on = 1'b0; cycles(4);
    end
    expect_key(1, 1);
    hold_release(60);

    // Two rows at once is not a key.
    kp_rows = 4'b0011;
    kp_col  = 2'd0;
    hold_release(60);

    // Reset in the middle of debouncing key 7.
    kp_rows = 4'b0100;
    kp_col  = 2'd0;
    kp_on   = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd1) seen = 1'b1;
    end
    check("debounce_reached", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    kp_on = 1'b0;
    m_last = '0;
    check("mid_rst_key_col", int'(key_col), 1);
    check("mid_rst_state", int'(dbg_state), 0);
    check("mid_rst_key_data", int'(key_data), 0);
    rst = 1'b0;
    cycles(40);
    check("mid_rst_drain", exp_q.size(), 0);

    // Random presses on random boards.
    repeat (30) begin
      for (int k = 1; k <= 9; k++) begin
        v = $urandom_range(0, 2);
        board[19-2*k] = (v == 2);
        board[18-2*k] = (v == 1);
      end
      result = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      press($urandom_range(0, 3), $urandom_range(0, 2));
    end

    cycles(20);
    check("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_move_scanner.md
Name: keypad_move_scanner

Overview:
- Upstream input stage for the tic-tac-toe game-state block.
- Scans a 4-row x 3-column matrix keypad and debounces the press.
- Maps the press to a cell number 1..9 and checks legality against the current board and result.
- Emits a one-cycle move strobe with key_data, which the game-state block consumes. Also emits reject and restart strobes.

Parameters:
SCAN_DIV, 24999, scan tick period in clk cycles minus 1 (tick every SCAN_DIV+1 cycles)
DEBOUNCE_TICKS, 20, consecutive scan ticks of a stable reading needed to accept a press or a release

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_row  input  4  keypad row lines, active-high, asynchronous to clk
key_col  output  3  keypad column drive, one-hot, active-high
board  input  18  current board; cell k (1..9) occupies bits 19-2k (O) and 18-2k (X)
result  input  2  game result; 00 in progress, 01 X win, 10 O win, 11 draw
key_data  output  4  last accepted legal cell number 1..9
key_valid  output  1  one-cycle strobe: legal move accepted, key_data updated on the same cycle
key_reject  output  1  one-cycle strobe: press accepted but the move is illegal
restart  output  1  one-cycle strobe: '*' key accepted

Behaviour:
- Reset values: key_col=001, key_data=0, key_valid=0, key_reject=0, restart=0, state=SCAN, tick counter=0, debounce counter=0.
- key_row passes through a 2-flop synchronizer. Only synchronized values are used.
- Tick counter: counts 0..SCAN_DIV, wraps, and pulses tick for one cycle at wrap. All FSM decisions happen on tick cycles only.
- Key code for row r (0..3), column c (0..2):
  - r<3: code=3r+c+1.
  - r=3: c0 = '*' (restart), c1 = '0' (ignored), c2 = '#' (ignored).
- A reading is valid only if exactly one synchronized row bit is set. Zero bits or two or more bits count as "no key".
- States:
  - SCAN:
    - On tick, if the reading is valid, latch row/column, clear the debounce counter, go to DEBOUNCE. key_col holds.
    - Otherwise rotate key_col left (001→010→100→001).
  - DEBOUNCE (key_col frozen):
    - On tick, if the reading equals the latched row, increment the counter.
    - Otherwise return to SCAN with no strobe; key_col resumes rotation from the current column.
    - When the counter reaches DEBOUNCE_TICKS, decide (below) and go to HOLD.
  - HOLD (key_col frozen):
    - On tick, a zero reading increments the release counter; any nonzero reading clears it.
    - At DEBOUNCE_TICKS consecutive zero ticks, go to SCAN.
    - No strobes are issued in HOLD. Auto-repeat is forbidden.
- Decision (board and result sampled on the deciding tick cycle; strobes are registered and high on the next cycle only):
  - Code 1..9, result==00, and both bits of cell k are 0: key_valid=1, key_data=k.
  - Code 1..9 otherwise (occupied cell or game over): key_reject=1; key_data unchanged.
  - '*': restart=1 regardless of result or board.
  - '0' or '#': no strobe.
- At most one strobe is high in any cycle. Strobes are never high in consecutive cycles.
- Board or result changing mid-debounce has no effect until the deciding tick.
- rst mid-DEBOUNCE or HOLD: abandon the press, issue no strobe, apply reset values on the next edge.
- Counter widths must hold SCAN_DIV and DEBOUNCE_TICKS without overflow.

Test Plan:
(Bench uses SCAN_DIV=3, DEBOUNCE_TICKS=4.)
- Reset, no key for 40 cycles → key_col cycles 001,010,100 every 4 clk; all strobes 0; key_data=0.
- Hold row0 when col=010 (key 2) on an empty board, result=00 → exactly one key_valid pulse with key_data=2, about 4 ticks after first detection; no further strobe while held. Release → SCAN resumes after 4 zero ticks.
- Set board[15:14]=01 (cell 2 has X), press key 2 → one key_reject pulse, no key_valid, key_data stays at its previous value.
- Result=01, press key 9 on an empty cell → key_reject. Press '*' (row3, col 001) → one restart pulse.
- Bounce: key 5 toggles on and off every tick for 3 ticks, then stays stable → no strobe during the bounce; one key_valid with key_data=5 after 4 stable ticks.
- Rows 0 and 1 asserted together → no strobe. Assert rst during DEBOUNCE of key 7 → no strobe, key_col=001, state SCAN.
